// File: rtl/rc4_encryptor.sv
// RC4 PRGA encryption engine: walks the pre-scheduled S-box, XORs the keystream
// into plaintext read from a message RAM and writes ciphertext, aborting on bytes
// outside the lowercase/space charset.
module rc4_encryptor #(
  parameter int DATA_WIDTH     = 8,
  parameter int S_ADDR_WIDTH   = 8,
  parameter int MSG_LENGTH     = 32,
  parameter int MSG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     sOut,
  output logic [DATA_WIDTH-1:0]     sIn,
  output logic [S_ADDR_WIDTH-1:0]   sAddr,
  output logic                      sWren,
  input  logic [DATA_WIDTH-1:0]     pOut,
  output logic [MSG_ADDR_WIDTH-1:0] pAddr,
  output logic [DATA_WIDTH-1:0]     cIn,
  output logic [MSG_ADDR_WIDTH-1:0] cAddr,
  output logic                      cWren,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [MSG_ADDR_WIDTH:0]   bytesWritten
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_INC_I, ST_RD_SI, ST_RD_SJ, ST_WR_SI,
    ST_WR_SJ, ST_RD_F, ST_WR_C, ST_DONE, ST_ERROR
  } state_t;

  state_t                    state;
  logic [S_ADDR_WIDTH-1:0]   i, j;
  logic [DATA_WIDTH-1:0]     si, sj;
  logic [MSG_ADDR_WIDTH-1:0] k;
  logic                      start_q;

  logic                      start_edge;
  logic                      can_start;
  logic                      pt_valid;
  logic                      last_byte;
  logic [S_ADDR_WIDTH-1:0]   j_sum;

  assign start_edge = start & ~start_q;
  assign can_start  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign j_sum      = j + S_ADDR_WIDTH'(sOut);
  assign last_byte  = (k == MSG_ADDR_WIDTH'(MSG_LENGTH - 1));
  assign pt_valid   = (pOut == DATA_WIDTH'(32)) ||
                      ((pOut >= DATA_WIDTH'(97)) && (pOut <= DATA_WIDTH'(122)));

  assign busy  = ~can_start;
  assign done  = (state == ST_DONE);
  assign error = (state == ST_ERROR);
  assign pAddr = k;
  assign cAddr = k;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      i            <= '0;
      j            <= '0;
      k            <= '0;
      si           <= '0;
      sj           <= '0;
      start_q      <= 1'b0;
      bytesWritten <= '0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_edge) begin
            i            <= '0;
            j            <= '0;
            k            <= '0;
            bytesWritten <= '0;
            state        <= ST_INC_I;
          end
        end
        ST_INC_I: begin
          i     <= i + S_ADDR_WIDTH'(1);
          state <= ST_RD_SI;
        end
        ST_RD_SI: begin
          si    <= sOut;
          j     <= j_sum;
          state <= ST_RD_SJ;
        end
        ST_RD_SJ: begin
          sj    <= sOut;
          state <= ST_WR_SI;
        end
        ST_WR_SI: state <= ST_WR_SJ;
        ST_WR_SJ: state <= ST_RD_F;
        ST_RD_F:  state <= ST_WR_C;
        ST_WR_C: begin
          if (pt_valid) begin
            bytesWritten <= bytesWritten + (MSG_ADDR_WIDTH + 1)'(1);
            if (last_byte) begin
              state <= ST_DONE;
            end else begin
              k     <= k + MSG_ADDR_WIDTH'(1);
              state <= ST_INC_I;
            end
          end else begin
            state <= ST_ERROR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM strobes are gated by reset so an abort never lands a write mid-swap.
  // NOTE: every output gets a default first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sAddr = '0;
    sIn   = '0;
    sWren = 1'b0;
    cIn   = '0;
    cWren = 1'b0;
    case (state)
      ST_INC_I: sAddr = i + S_ADDR_WIDTH'(1);
      ST_RD_SI: sAddr = j_sum;
      ST_RD_SJ: sAddr = i;
      ST_WR_SI: begin
        sAddr = i;
        sIn   = sj;
        sWren = ~reset;
      end
      ST_WR_SJ: begin
        sAddr = j;
        sIn   = si;
        sWren = ~reset;
      end
      ST_RD_F: sAddr = S_ADDR_WIDTH'(si) + S_ADDR_WIDTH'(sj);
      ST_WR_C: begin
        if (pt_valid) begin
          cIn   = pOut ^ sOut;
          cWren = ~reset;
        end
      end
      default: ;
    endcase
  end

endmodule
